sdp_ram_param: RTL

//  Parametrised single-clock simple-dual-port RAM: one write port (A), one read port (B).

---
 rtl/sdp_ram_param.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sdp_ram_param.sv
// rtl/sdp_ram_param.sv - parametrised single-clock simple-dual-port RAM
// One write port, one read port, optional output register, RDW forwarding and a post-reset clear.
module sdp_ram_param #(
  parameter int                DATA_W         = 24,
  parameter int                ADDR_W         = 6,
  parameter int                READ_MODE      = 0,
  parameter int                RDW_MODE       = 0,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cea,
  input  logic [ADDR_W-1:0] ada,
  input  logic [DATA_W-1:0] din,
  input  logic              ceb,
  input  logic [ADDR_W-1:0] adb,
  input  logic              oce,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              init_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_done_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic              rdw_fwd;
  logic              v1_d;
  logic              v1_q;
  logic [DATA_W-1:0] rd1_q;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end
        end
        default: init_done_q <= 1'b1;
      endcase
    end
  end

  // The clear sequencer owns the write port until the last word is written.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ada;
    mem_wdata = din;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VAL;
      end else begin
        mem_we = cea & init_done_q;
      end
    end
  end

  always_comb begin
    rd_en   = ceb & init_done_q & ~reset;
    rdw_fwd = (RDW_MODE != 0) && cea && (ada == adb);
    v1_d    = rd_en;
  end

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      v1_q <= v1_d;
      if (rd_en) begin
        rd1_q <= rdw_fwd ? din : mem[adb];
      end
    end
  end

  generate
    if (READ_MODE != 0) begin : g_oreg
      logic [DATA_W-1:0] dout_q;
      logic              dout_valid_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else if (oce) begin
          dout_q       <= rd1_q;
          dout_valid_q <= v1_q;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
    end else begin : g_bypass
      logic unused_oce;
      assign unused_oce = oce;
      assign dout       = rd1_q;
      assign dout_valid = v1_q;
    end
  endgenerate

  assign init_done = init_done_q;

endmodule
